aes_inv_core: RTL
=================

# aes_inv_core

Iterative AES-128 inverse cipher: accepts a 128-bit ciphertext and cipher key over a valid/ready handshake and returns the 128-bit plaintext. It processes one round per clock. The block owns its control FSM and an 11-entry round-key store, so a repeated key skips re-expansion. It is the decrypt counterpart of the encrypt datapath and uses the same FIPS-197 byte ordering: byte 0 = bits [127:120], column-major state.

## Interface
Parameters:
- none; AES-128 only, NR=10 fixed in package

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ciphertext/key request valid
- in_ready  out  1  block can accept; high only in IDLE
- cipher_text  in  128  ciphertext, sampled on accept
- cipher_key  in  128  key, sampled on accept when key_new=1
- key_new  in  1  1 = expand cipher_key; 0 = reuse stored round keys
- out_valid  out  1  plain_text valid; held until taken
- out_ready  in  1  consumer accepts plain_text
- plain_text  out  128  result, stable while out_valid=1
- busy  out  1  high in KEXP or DEC

## Operation
- FSM states: IDLE, KEXP, DEC, DONE.
- Accept: in_valid & in_ready at a rising edge. Registers ct ← cipher_text.
- Transition on accept: if key_new=1 or key_valid=0, load rk[0] ← cipher_key and go to KEXP. Otherwise go to DEC.
- KEXP, rnd counter 1..10: rk[rnd] ← KeyExpand(rk[rnd-1], Rcon[rnd]). After rnd=10, set key_valid=1 and go to DEC.
- DEC, rnd counter 10 down to 0:
  - rnd=10: st ← ct ^ rk[10].
  - rnd 9..1: st ← InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[rnd]).
  - rnd=0: st ← InvSubBytes(InvShiftRows(st)) ^ rk[0], then go to DONE.
- DONE: out_valid=1 and plain_text=st. On out_ready, go to IDLE.
- key_new=1 while key_valid=1: stored keys are overwritten. There is no partial-reuse path.
- in_valid while not in IDLE: ignored, because in_ready=0. cipher_text, cipher_key and key_new are not sampled.
- out_ready while out_valid=0: no effect.
- Reset (any state, mid-operation included):
  - state=IDLE, rnd=0, st=0, ct=0.
  - All rk entries = 0, key_valid=0.
  - The in-flight operation is dropped; no out_valid pulse.

## Timing
- Reset values: in_ready=1, out_valid=0, plain_text=0, busy=0.
- Latency from accept edge E to the first edge with out_valid=1:
  - new key: E+21 (10 KEXP + 11 DEC cycles).
  - reused key: E+11.
- The output handshake completes on the edge with out_valid & out_ready. in_ready rises the cycle after.
- Minimum accept-to-accept spacing: 13 cycles (reused key, out_ready held high).
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- aes_pkg holds:
  - state enum.
  - NR=10.
  - Rcon[1..10] constant array.
  - functions sbox, inv_sbox, xtime/gf_mul.
  - word rotate, and InvShiftRows/InvMixColumns as pure functions.
- Sub-module aes_inv_round: combinational. Inputs st, rk, and a last flag that bypasses InvMixColumns. Output is the next state. Instantiated once.
- Key expansion step is a package function called inline. The rk store is an 11×128 register array inside aes_inv_core.

## Test plan
- FIPS-197 App. B, key_new=1: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plain_text 3243f6a8885a308d313198a2e0370734, out_valid exactly 21 cycles after accept.
- FIPS-197 C.1, key 000102030405060708090a0b0c0d0e0f: first ct 69c4e0d86a7b0430d8cdb78070b4c55a with key_new=1, then the same ct with key_new=0 -> 00112233445566778899aabbccddeeff both times, latency 21 then 11.
- Backpressure: hold out_ready=0 for 30 cycles -> out_valid and plain_text stable and in_ready=0 throughout. Pulse in_valid during this window with other data -> ignored, and the next result is unaffected.
- key_new=0 as the first request after reset -> forced expansion, latency 21, correct result.
- Assert rst during DEC round 5 -> next cycle in_ready=1, out_valid=0, busy=0, plain_text=0. A following key_new=0 request expands (latency 21), proving key_valid was cleared.
- 200 random key/ct pairs with random key_new and random out_ready stalls -> every result matches the reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, FSM state type and GF(2^8)/state helper functions
// Purpose: shared definitions for the iterative AES-128 inverse cipher.
// Ports: none (package). Byte 0 of a 128-bit state is bits [127:120], column-major.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  localparam int NR = 10;

  // Entry 0 is never used; round constants are indexed by round 1..10.
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                         8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 (product of a^2 .. a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] x;
    x = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-128 key schedule step: previous round key -> next round key.
  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(prev[31:0])) ^ {rcon, 24'h000000};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Row r is rotated right by r columns: out(r,c) = in(r,(c-r) mod 4).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
// Purpose: result = [InvMixColumns](InvSubBytes(InvShiftRows(st)) ^ rk).
// Ports: st (state in), rk (round key), last (skip InvMixColumns), result (next state).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] result
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  always_comb begin
    shifted = inv_shift_rows(st);
    subbed  = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]);
    end
    keyed  = subbed ^ rk;
    result = last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_inv_core.sv
// rtl/aes_inv_core.sv - iterative AES-128 inverse cipher, one round per clock
// Purpose: decrypts cipher_text with a stored or freshly expanded key schedule.
// Ports: clk, rst (async, active-high); in_valid/in_ready with cipher_text, cipher_key,
//        key_new; out_valid/out_ready with plain_text; busy (KEXP or DEC).
module aes_inv_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  input  logic         key_new,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_text,
  output logic         busy
);

  state_t       state;
  state_t       state_next;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] ct;
  logic [127:0] rk [0:10];
  logic         key_valid;
  logic [127:0] round_out;
  logic         expand;

  // Expansion is forced when no schedule has been built since reset.
  assign expand = key_new || !key_valid;

  aes_inv_round u_round (
    .st     (st),
    .rk     (rk[rnd]),
    .last   (rnd == 4'd0),
    .result (round_out)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = expand ? KEXP : DEC;
      KEXP:    if (rnd == 4'(NR)) state_next = DEC;
      DEC:     if (rnd == 4'd0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      st        <= '0;
      ct        <= '0;
      key_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ct <= cipher_text;
            if (expand) begin
              rk[0]     <= cipher_key;
              key_valid <= 1'b0;
              rnd       <= 4'd1;
            end else begin
              rnd <= 4'(NR);
            end
          end
        end
        KEXP: begin
          rk[rnd] <= key_expand(rk[rnd - 4'd1], RCON[rnd]);
          if (rnd == 4'(NR)) begin
            key_valid <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DEC: begin
          // The first decrypt cycle is only the initial AddRoundKey with rk[10].
          if (rnd == 4'(NR)) st <= ct ^ rk[NR];
          else               st <= round_out;
          if (rnd != 4'd0) rnd <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state == KEXP) || (state == DEC);
  assign plain_text = st;

endmodule
